// File: rtl/riscv_fwd_sel_gen.sv
// EX-stage operand forwarding select generator with load-use stall detection.
// Define RISCV_FWD_WB_BYPASS_EN to track WB producers and emit select 11.
module riscv_fwd_sel_gen #(
   parameter int unsigned RF_AW = 5
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_id_vld,
   input  logic [RF_AW-1:0] i_id_rs1,
   input  logic [RF_AW-1:0] i_id_rs2,
   input  logic [RF_AW-1:0] i_id_rd,
   input  logic             i_id_rd_we,
   input  logic             i_id_is_load,
   input  logic             i_hold,
   input  logic             i_flush,
   output logic [1:0]       o_fwd_sel_a,
   output logic [1:0]       o_fwd_sel_b,
   output logic             o_load_use_stall
);

   logic             ex_vld_q, ex_ld_q, mem_vld_q;
   logic [RF_AW-1:0] ex_rd_q, mem_rd_q;
   logic             hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
   logic             bubble, id_wr;
   logic [1:0]       sel_a_d, sel_b_d;
`ifdef RISCV_FWD_WB_BYPASS_EN
   logic             wb_vld_q;
   logic [RF_AW-1:0] wb_rd_q;
   logic             hit_wb_a, hit_wb_b;
`endif

   always_comb begin
      hit_ex_a  = ex_vld_q  && (ex_rd_q  == i_id_rs1) && (i_id_rs1 != '0);
      hit_ex_b  = ex_vld_q  && (ex_rd_q  == i_id_rs2) && (i_id_rs2 != '0);
      hit_mem_a = mem_vld_q && (mem_rd_q == i_id_rs1) && (i_id_rs1 != '0);
      hit_mem_b = mem_vld_q && (mem_rd_q == i_id_rs2) && (i_id_rs2 != '0);
`ifdef RISCV_FWD_WB_BYPASS_EN
      hit_wb_a  = wb_vld_q  && (wb_rd_q  == i_id_rs1) && (i_id_rs1 != '0);
      hit_wb_b  = wb_vld_q  && (wb_rd_q  == i_id_rs2) && (i_id_rs2 != '0);
`endif

      o_load_use_stall = i_id_vld && ex_ld_q && (hit_ex_a || hit_ex_b);
      bubble           = o_load_use_stall || i_flush || !i_id_vld;
      id_wr            = !bubble && i_id_rd_we && (i_id_rd != '0);

      // Youngest producer wins: EX beats MEM beats WB.
      sel_a_d = 2'b00;
      if (hit_ex_a)       sel_a_d = 2'b01;
      else if (hit_mem_a) sel_a_d = 2'b10;
`ifdef RISCV_FWD_WB_BYPASS_EN
      else if (hit_wb_a)  sel_a_d = 2'b11;
`endif

      sel_b_d = 2'b00;
      if (hit_ex_b)       sel_b_d = 2'b01;
      else if (hit_mem_b) sel_b_d = 2'b10;
`ifdef RISCV_FWD_WB_BYPASS_EN
      else if (hit_wb_b)  sel_b_d = 2'b11;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ex_vld_q    <= 1'b0;
         ex_ld_q     <= 1'b0;
         ex_rd_q     <= '0;
         mem_vld_q   <= 1'b0;
         mem_rd_q    <= '0;
         o_fwd_sel_a <= 2'b00;
         o_fwd_sel_b <= 2'b00;
      end else if (!i_hold) begin
         ex_vld_q    <= id_wr;
         ex_ld_q     <= id_wr && i_id_is_load;
         ex_rd_q     <= i_id_rd;
         mem_vld_q   <= ex_vld_q;
         mem_rd_q    <= ex_rd_q;
         o_fwd_sel_a <= bubble ? 2'b00 : sel_a_d;
         o_fwd_sel_b <= bubble ? 2'b00 : sel_b_d;
      end
   end

`ifdef RISCV_FWD_WB_BYPASS_EN
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wb_vld_q <= 1'b0;
         wb_rd_q  <= '0;
      end else if (!i_hold) begin
         wb_vld_q <= mem_vld_q;
         wb_rd_q  <= mem_rd_q;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_fwd_sel_gen.sv
// Self-checking bench for riscv_fwd_sel_gen: history-queue model plus directed literal checks.
module tb_riscv_fwd_sel_gen;

`ifdef RISCV_FWD_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk, rstn;
   logic       id_vld, id_rd_we, id_is_load, hold, flush;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [1:0] sel_a, sel_b;
   logic       stall;

   int checks = 0;
   int errors = 0;

   riscv_fwd_sel_gen #(.RF_AW(5)) dut (
      .i_clk           (clk),
      .i_rstn          (rstn),
      .i_id_vld        (id_vld),
      .i_id_rs1        (id_rs1),
      .i_id_rs2        (id_rs2),
      .i_id_rd         (id_rd),
      .i_id_rd_we      (id_rd_we),
      .i_id_is_load    (id_is_load),
      .i_hold          (hold),
      .i_flush         (flush),
      .o_fwd_sel_a     (sel_a),
      .o_fwd_sel_b     (sel_b),
      .o_load_use_stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: list of what entered EX, youngest first; distance to producer sets the select.
   typedef struct {
      logic       wr;
      logic [4:0] rd;
      logic       ld;
   } rec_t;

   rec_t       hist[$];
   logic [1:0] exp_a, exp_b;

   function automatic logic [1:0] sel_for(input logic [4:0] rs);
      int depth = BYP ? 3 : 2;
      if (rs == 5'd0) return 2'b00;
      for (int k = 0; k < hist.size() && k < depth; k++)
         if (hist[k].wr && hist[k].rd == rs) return 2'(k + 1);
      return 2'b00;
   endfunction

   function automatic logic model_stall();
      if (!id_vld || hist.size() == 0) return 1'b0;
      if (!(hist[0].wr && hist[0].ld)) return 1'b0;
      return (id_rs1 != 5'd0 && hist[0].rd == id_rs1) || (id_rs2 != 5'd0 && hist[0].rd == id_rs2);
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist.delete();
         exp_a = 2'b00;
         exp_b = 2'b00;
      end else if (!hold) begin
         logic bub;
         rec_t r;
         bub   = model_stall() || flush || !id_vld;
         exp_a = bub ? 2'b00 : sel_for(id_rs1);
         exp_b = bub ? 2'b00 : sel_for(id_rs2);
         r.wr  = !bub && id_rd_we && id_rd != 5'd0;
         r.rd  = id_rd;
         r.ld  = r.wr && id_is_load;
         hist.push_front(r);
         if (hist.size() > 3) hist.delete(3);
      end
   end

   always @(negedge clk) begin
      logic es;
      es = model_stall();
      checks++;
      if (sel_a !== exp_a || sel_b !== exp_b || stall !== es) begin
         errors++;
         $display("FAIL model t=%0t sel_a=%b sel_b=%b stall=%b, required sel_a=%b sel_b=%b stall=%b",
                  $time, sel_a, sel_b, stall, exp_a, exp_b, es);
      end
   end

   task automatic chk(input string name, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es);
      checks++;
      if (sel_a !== ea || sel_b !== eb || stall !== es) begin
         errors++;
         $display("FAIL %s sel_a=%b sel_b=%b stall=%b, required sel_a=%b sel_b=%b stall=%b",
                  name, sel_a, sel_b, stall, ea, eb, es);
      end
   endtask

   // Present one ID slot for one cycle; returns at the following negedge.
   task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic hd = 1'b0, input logic fl = 1'b0);
      @(posedge clk);
      #1;
      id_vld = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_rd_we = we; id_is_load = ld; hold = hd; flush = fl;
      @(negedge clk);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      id_vld = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd0;
      id_rd_we = 1'b0; id_is_load = 1'b0; hold = 1'b0; flush = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("reset", 2'b00, 2'b00, 1'b0);
      end
      @(posedge clk);
      #1 rstn = 1'b1;
      cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); chk("post_reset0", 2'b00, 2'b00, 1'b0);
      cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); chk("post_reset1", 2'b00, 2'b00, 1'b0);

      // back-to-back, one gap, two gaps
      nops(3);
      cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      cyc(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      nops(1); chk("b2b", 2'b01, 2'b01, 1'b0);
      nops(3);
      cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      nops(1);
      cyc(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      nops(1); chk("gap1", 2'b10, 2'b10, 1'b0);
      nops(3);
      cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      nops(2);
      cyc(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      nops(1); chk("gap2", BYP ? 2'b11 : 2'b00, BYP ? 2'b11 : 2'b00, 1'b0);

      // load-use
      nops(3);
      cyc(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      cyc(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0); chk("lu_stall", 2'b00, 2'b00, 1'b1);
      cyc(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0); chk("lu_bubble", 2'b00, 2'b00, 1'b0);
      nops(1); chk("lu_fwd", 2'b10, 2'b00, 1'b0);

      // priority
      nops(3);
      cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      cyc(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0);
      nops(1); chk("priority", 2'b01, 2'b01, 1'b0);

      // x0
      nops(3);
      cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
      cyc(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0); chk("x0_id", 2'b00, 2'b00, 1'b0);
      nops(1); chk("x0_sel", 2'b00, 2'b00, 1'b0);
      cyc(1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1);
      cyc(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0); chk("x0_load", 2'b00, 2'b00, 1'b0);

      // hold
      nops(3);
      cyc(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
      cyc(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0);
      cyc(1'b1, 5'd12, 5'd11, 5'd13, 1'b1, 1'b0, 1'b1); chk("hold0", 2'b01, 2'b00, 1'b0);
      cyc(1'b1, 5'd12, 5'd11, 5'd13, 1'b1, 1'b0, 1'b1); chk("hold1", 2'b01, 2'b00, 1'b0);
      cyc(1'b1, 5'd12, 5'd11, 5'd13, 1'b1, 1'b0, 1'b1); chk("hold2", 2'b01, 2'b00, 1'b0);
      cyc(1'b1, 5'd12, 5'd11, 5'd13, 1'b1, 1'b0); chk("hold3", 2'b01, 2'b00, 1'b0);
      nops(1); chk("resume", 2'b01, 2'b10, 1'b0);

      // flush
      nops(3);
      cyc(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
      cyc(1'b1, 5'd13, 5'd13, 5'd20, 1'b1, 1'b0, 1'b0, 1'b1);
      nops(1); chk("flush_sel", 2'b00, 2'b00, 1'b0);
      cyc(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 5'd14, 5'd14, 5'd21, 1'b1, 1'b0);
      nops(1); chk("squash", 2'b00, 2'b00, 1'b0);
      nops(3);
      cyc(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1);
      cyc(1'b1, 5'd15, 5'd0, 5'd22, 1'b1, 1'b0, 1'b0, 1'b1); chk("flush_stall", 2'b00, 2'b00, 1'b1);
      nops(1); chk("flush_stall_sel", 2'b00, 2'b00, 1'b0);

      // reset mid-operation
      nops(3);
      cyc(1'b1, 5'd0, 5'd0, 5'd16, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      id_vld = 1'b1; id_rs1 = 5'd16; id_rs2 = 5'd16; id_rd = 5'd23;
      id_rd_we = 1'b1; id_is_load = 1'b0;
      #1 rstn = 1'b0;
      #2 rstn = 1'b1;
      @(negedge clk); chk("rst_mid", 2'b00, 2'b00, 1'b0);
      nops(1); chk("rst_mid_fwd", 2'b00, 2'b00, 1'b0);

      // mixed traffic on a small register set, checked by the model only
      for (int i = 0; i < 200; i++)
         cyc(($urandom % 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom % 4) != 0, ($urandom % 3) == 0,
             ($urandom % 8) == 0, ($urandom % 8) == 0);

      nops(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
